// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a small RX FIFO and a bus register port.
// Registers (addr[3:2]): DATA (read pops), STATUS (W1C error flags), CTRL (irq_en).
module uart_rx #(
    parameter int ClockFrequency = 50_000_000,
    parameter int BaudRate       = 115_200,
    parameter int FifoDepth      = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        device_req_i,
    input  logic [31:0] device_addr_i,
    input  logic        device_we_i,
    input  logic [3:0]  device_be_i,
    input  logic [31:0] device_wdata_i,
    output logic        device_rvalid_o,
    output logic [31:0] device_rdata_o,
    input  logic        uart_rx_i,
    output logic        rx_irq_o
);

    localparam int ClocksPerBit = ClockFrequency / BaudRate;
    localparam int CntW         = $clog2(ClocksPerBit);
    localparam int AW           = $clog2(FifoDepth);

    localparam logic [CntW-1:0] HalfLoad = CntW'(ClocksPerBit / 2 - 1);
    localparam logic [CntW-1:0] FullLoad = CntW'(ClocksPerBit - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state, state_n;
    logic [CntW-1:0]   cnt, cnt_n;
    logic [2:0]        idx, idx_n;
    logic [7:0]        shift, shift_n;
    logic              push, frame_set;

    logic              sync1, sync2, prev;
    logic              fall;

    logic [7:0]        mem [FifoDepth];
    logic [AW:0]       wptr, rptr;
    logic              not_empty, full, pop, do_push;
    logic              overflow, frame_err, irq_en, ovf_set;

    logic [1:0]        sel;
    logic              rd, wr;
    logic [31:0]       rdata_n;
    logic              unused;

    assign unused = ^{device_be_i, device_addr_i[31:4], device_addr_i[1:0],
                      device_wdata_i[31:4], device_wdata_i[1]};

    // Two-flop synchronizer plus a delayed copy for falling-edge detection.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= uart_rx_i;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign fall = prev & ~sync2;

    // Receiver state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_n;
    end

    // Bit timer, bit index and shift register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
        end else begin
            cnt   <= cnt_n;
            idx   <= idx_n;
            shift <= shift_n;
        end
    end

    // Receiver next-state: mid-bit sampling driven by the down-counting bit timer.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        idx_n     = idx;
        shift_n   = shift;
        push      = 1'b0;
        frame_set = 1'b0;
        case (state)
            IDLE: begin
                if (fall) begin
                    state_n = START;
                    cnt_n   = HalfLoad;
                end
            end
            START: begin
                if (cnt == '0) begin
                    if (sync2) begin
                        state_n = IDLE;
                    end else begin
                        state_n = DATA;
                        cnt_n   = FullLoad;
                        idx_n   = '0;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            DATA: begin
                if (cnt == '0) begin
                    shift_n[idx] = sync2;
                    cnt_n        = FullLoad;
                    if (idx == 3'd7) state_n = STOP;
                    else             idx_n   = idx + 1'b1;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            STOP: begin
                if (cnt == '0) begin
                    state_n = IDLE;
                    if (sync2) push      = 1'b1;
                    else       frame_set = 1'b1;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign sel       = device_addr_i[3:2];
    assign rd        = device_req_i & ~device_we_i;
    assign wr        = device_req_i & device_we_i;
    assign not_empty = (wptr != rptr);
    assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop       = rd && (sel == 2'd0) && not_empty;
    // A full FIFO still accepts a byte when the same cycle pops one.
    assign do_push   = push && (!full || pop);
    assign ovf_set   = push && full && !pop;

    // FIFO storage; flushing is done by resetting the pointers.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wptr[AW-1:0]] <= shift;
    end

    // FIFO pointers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (pop)     rptr <= rptr + 1'b1;
        end
    end

    // Sticky error flags (a new event wins over a same-cycle clear) and irq enable.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
            irq_en    <= 1'b0;
        end else begin
            overflow  <= (overflow & ~(wr && sel == 2'd1 && device_wdata_i[2])) | ovf_set;
            frame_err <= (frame_err & ~(wr && sel == 2'd1 && device_wdata_i[3])) | frame_set;
            if (wr && sel == 2'd2) irq_en <= device_wdata_i[0];
        end
    end

    // Read data mux for the registered bus response.
    always_comb begin
        rdata_n = '0;
        if (rd) begin
            case (sel)
                2'd0:    rdata_n = not_empty ? {24'b0, mem[rptr[AW-1:0]]} : 32'b0;
                2'd1:    rdata_n = {28'b0, frame_err, overflow, full, not_empty};
                2'd2:    rdata_n = {31'b0, irq_en};
                default: rdata_n = '0;
            endcase
        end
    end

    // Bus response one cycle after every request.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            device_rvalid_o <= 1'b0;
            device_rdata_o  <= '0;
        end else begin
            device_rvalid_o <= device_req_i;
            device_rdata_o  <= rdata_n;
        end
    end

    assign rx_irq_o = irq_en & (not_empty | overflow | frame_err);

endmodule
